// File: rtl/hex_byte_assembler.sv
// hex_byte_assembler: builds a byte from two hex nibble entries (top first), drives an
// active-low LED bank and a registered byte with a one-cycle valid strobe.
// Abandons a half-entered byte after TIMEOUT_CYCLES idle cycles.
// Optional build macro HEX_ASSEMBLER_ECHO_EN shows the pending top nibble on ledOut[7:4].
module hex_byte_assembler #(
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic [3:0] nibbleIn,
  input  logic       nibbleValid,
  input  logic       clearReq,
  output logic [7:0] byteOut,
  output logic       byteValid,
  output logic [7:0] ledOut,
  output logic       partial,
  output logic       errTimeout
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, HAVE_TOP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    top_q, top_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    byte_q, byte_d;
  logic [7:0]    led_q, led_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          tmo_hit;

  assign tmo_hit = (state_q == HAVE_TOP) && (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state_q <= IDLE;
    else state_q <= state_d;
  end

  // Next state: clear beats a nibble entry, which beats the timeout
  always_comb begin
    state_d = state_q;
    if (clearReq) state_d = IDLE;
    else if (nibbleValid) state_d = (state_q == IDLE) ? HAVE_TOP : IDLE;
    else if (tmo_hit) state_d = IDLE;
  end

  // Datapath and output next values, same priority as the state transition
  always_comb begin
    top_d   = top_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    led_d   = led_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (clearReq) begin
      led_d = 8'hFF;
      cnt_d = '0;
    end else if (nibbleValid) begin
      cnt_d = '0;
      if (state_q == IDLE) begin
        top_d = nibbleIn;
`ifdef HEX_ASSEMBLER_ECHO_EN
        led_d = {~nibbleIn, 4'hF};
`endif
      end else begin
        byte_d  = {top_q, nibbleIn};
        led_d   = ~{top_q, nibbleIn};
        valid_d = 1'b1;
      end
    end else if (tmo_hit) begin
      err_d = 1'b1;
      cnt_d = '0;
`ifdef HEX_ASSEMBLER_ECHO_EN
      led_d = 8'hFF;
`endif
    end else if (state_q == HAVE_TOP) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Datapath and output registers; reset discards any half-entered nibble
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      top_q   <= 4'h0;
      cnt_q   <= '0;
      byte_q  <= 8'h00;
      led_q   <= 8'hFF;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      top_q   <= top_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      led_q   <= led_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign byteOut    = byte_q;
  assign byteValid  = valid_q;
  assign ledOut     = led_q;
  assign errTimeout = err_q;
  assign partial    = (state_q == HAVE_TOP);
endmodule

// File: doc/hex_byte_assembler.md
# hex_byte_assembler

Assembles two sequentially entered hex nibbles into one byte, top nibble first, then bottom nibble. The result drives an active-low 8-LED bank and a registered byte output with a one-cycle valid strobe. The block is the write-side counterpart of the DIP-switch nibble splitter: keypad/button nibble entries go in, and an inverted byte comes out for active-low hardware. A timeout abandons a half-entered byte.

## Interface
- TIMEOUT_CYCLES, default 100_000_000: maximum cycles allowed between the top-nibble and bottom-nibble entries; must be ≥ 2.
- clk  input  1  system clock; all state changes on its rising edge.
- rstN  input  1  reset, asynchronous, active-low.
- nibbleIn  input  4  hex digit being entered; sampled only when nibbleValid = 1.
- nibbleValid  input  1  single-cycle entry strobe.
- clearReq  input  1  abandons any partial entry and blanks the LEDs.
- byteOut  output  8  last completed byte, {top, bottom}, active-high.
- byteValid  output  1  one-cycle pulse when byteOut updates.
- ledOut  output  8  active-low LED drive.
- partial  output  1  high while waiting for the bottom nibble.
- errTimeout  output  1  one-cycle pulse when a partial entry times out.

## Operation
- States:
  - IDLE: waiting for the top nibble.
  - HAVE_TOP: top nibble latched, waiting for the bottom nibble.
- Reset values: state IDLE, byteOut 8'h00, byteValid 0, ledOut 8'hFF (all LEDs off), partial 0, errTimeout 0, timeout counter 0, top register 4'h0.
- IDLE + nibbleValid:
  - Latch nibbleIn into the top register.
  - Clear the counter.
  - Go to HAVE_TOP.
- HAVE_TOP + nibbleValid:
  - byteOut ← {top, nibbleIn}.
  - ledOut ← ~{top, nibbleIn}.
  - Pulse byteValid.
  - Go to IDLE.
- HAVE_TOP without nibbleValid:
  - Counter increments each cycle.
  - When the counter reaches TIMEOUT_CYCLES-1, the next edge goes to IDLE, pulses errTimeout and clears the counter.
  - byteOut and ledOut are unchanged by a timeout.
- clearReq, in any state:
  - Next edge goes to IDLE, sets ledOut to 8'hFF and clears the counter.
  - byteOut is retained; no byteValid, no errTimeout.
- Priority: clearReq > nibbleValid > timeout.
  - Valid in the same cycle the timeout would fire: treated as the bottom nibble and the byte completes.
- partial = (state == HAVE_TOP), decoded from registered state.
- Counter width is $clog2(TIMEOUT_CYCLES). It never wraps, because it is cleared on every exit from HAVE_TOP.
- Asserting rstN low mid-entry returns all outputs to their reset values asynchronously. The half-entered nibble is discarded.

## Timing
- All outputs are registered.
- byteValid, byteOut and ledOut update on the same rising edge that samples the second nibbleValid. Latency is 1 edge.
- byteValid and errTimeout are high for exactly one cycle.
- Back-to-back nibbleValid on consecutive cycles is legal: entries 1 and 2 form a byte, entry 3 starts a new top nibble.
- nibbleValid held high for N cycles counts as N entries. Edge-qualifying the strobe is the upstream debouncer's job.
- errTimeout fires on edge k+TIMEOUT_CYCLES, where k is the edge that latched the top nibble, provided no valid or clear arrives in between.

## Configuration
- HEX_ASSEMBLER_ECHO_EN, when defined:
  - On the top-nibble latch, ledOut[7:4] ← ~top and ledOut[3:0] ← 4'hF, so the half-entered digit is visible.
  - On timeout, ledOut returns to 8'hFF.
- When undefined:
  - ledOut changes only on byte completion, clearReq or reset.
  - The top-nibble entry and timeouts do not change ledOut.
- All other behaviour is identical in both builds.

## Test plan
Benches use TIMEOUT_CYCLES = 8.
- Reset, then enter 4'hA and 4'h5 on non-adjacent cycles:
  - byteOut = 8'hA5, ledOut = 8'h5A.
  - byteValid is a single pulse on the second entry's edge.
  - partial is high between the two entries.
- Three consecutive-cycle strobes 4'h1, 4'h2, 4'h3:
  - byteOut = 8'h12 with one byteValid.
  - partial = 1 afterwards, holding top 4'h3.
- Enter 4'hC, then 8 idle cycles:
  - errTimeout pulses once on the 8th edge after the latch, back to IDLE.
  - ledOut returns to 8'hFF with ECHO_EN; unchanged without it.
  - The next strobes 4'h0 and 4'h7 give byteOut 8'h07.
- Enter 4'hC, then nibbleValid with 4'hD on the cycle the timeout would fire:
  - byteOut = 8'hCD, byteValid = 1, no errTimeout.
- After byte 8'h3F, assert clearReq together with nibbleValid:
  - ledOut = 8'hFF, byteOut stays 8'h3F, state IDLE, no byteValid.
- Enter 4'h9, drop rstN for 1 ns mid-cycle:
  - All outputs return to reset values immediately.
  - The next two entries 4'h4 and 4'h2 give byteOut 8'h42.
